// File: rtl/mem_0_stage.sv
// First data-memory pipeline stage: registers EX results for Mem_1 and owns an in-order store buffer.
// Optional STORE_FWD_EN: loads hitting the buffer forward the youngest matching data instead of stalling.
module mem_0_stage #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_m0_oper,
  input  logic              ex_m0_readmem,
  input  logic              ex_m0_writemem,
  input  logic [31:0]       ex_m0_alu_out,
  input  logic [31:0]       ex_m0_regb,
  input  logic [4:0]        ex_m0_regdest,
  input  logic              ex_m0_writereg,
  output logic              m0_ex_stall,
  output logic              m0_m1_oper,
  output logic              m0_m1_readmem,
  output logic              m0_m1_writemem,
  output logic              m0_m1_writereg,
  output logic [31:0]       m0_m1_data_addr,
  output logic [31:0]       m0_m1_regb,
  output logic [4:0]        m0_m1_regdest,
  output logic              m0_m1_fwd_valid,
  output logic [31:0]       m0_m1_fwd_data,
  output logic              dmem_wre,
  output logic [ADDR_W-1:0] dmem_waddr,
  output logic [31:0]       dmem_wdata
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [31:0]       sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] ex_waddr;
  logic              is_store, is_load, sb_full, sb_empty;
  logic              hit, accept, push, pop, port_free;
  logic [PTR_W-1:0]  idx;
`ifdef STORE_FWD_EN
  logic [31:0]       hit_data;
`endif

  assign ex_waddr = ex_m0_alu_out[ADDR_W+1:2];
  assign is_store = ex_m0_oper & ex_m0_writemem & ~ex_m0_readmem;
  assign is_load  = ex_m0_oper & ex_m0_readmem;
  assign sb_full  = (count == CNT_W'(SB_DEPTH));
  assign sb_empty = (count == '0);

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (sb_addr[idx] == ex_waddr)) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        hit_data = sb_data[idx];
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  assign m0_ex_stall = is_store & sb_full;
`else
  assign m0_ex_stall = (is_store & sb_full) | (is_load & hit);
`endif

  assign accept     = ex_m0_oper & ~m0_ex_stall;
  assign push       = accept & is_store;
  assign port_free  = ~(m0_m1_oper & m0_m1_readmem);
  assign pop        = port_free & ~sb_empty;
  assign dmem_wre   = pop;
  assign dmem_waddr = sb_empty ? '0 : sb_addr[head];
  assign dmem_wdata = sb_empty ? '0 : sb_data[head];

  // Store buffer: a full buffer always stalls the store, so push never collides with an unpopped head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
      end
    end else begin
      if (push) begin
        sb_addr[tail] <= ex_waddr;
        sb_data[tail] <= ex_m0_regb;
        tail          <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Stalls and bubbles clear the whole bundle; the buffer, not Mem_1, performs store writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_m1_oper      <= 1'b0;
      m0_m1_readmem   <= 1'b0;
      m0_m1_writemem  <= 1'b0;
      m0_m1_writereg  <= 1'b0;
      m0_m1_data_addr <= '0;
      m0_m1_regb      <= '0;
      m0_m1_regdest   <= '0;
    end else if (accept) begin
      m0_m1_oper      <= 1'b1;
      m0_m1_readmem   <= ex_m0_readmem;
      m0_m1_writemem  <= ex_m0_writemem & ~is_store;
      m0_m1_writereg  <= ex_m0_writereg;
      m0_m1_data_addr <= ex_m0_alu_out;
      m0_m1_regb      <= ex_m0_regb;
      m0_m1_regdest   <= ex_m0_regdest;
    end else begin
      m0_m1_oper      <= 1'b0;
      m0_m1_readmem   <= 1'b0;
      m0_m1_writemem  <= 1'b0;
      m0_m1_writereg  <= 1'b0;
      m0_m1_data_addr <= '0;
      m0_m1_regb      <= '0;
      m0_m1_regdest   <= '0;
    end
  end

`ifdef STORE_FWD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_m1_fwd_valid <= 1'b0;
      m0_m1_fwd_data  <= '0;
    end else if (accept && is_load && hit) begin
      m0_m1_fwd_valid <= 1'b1;
      m0_m1_fwd_data  <= hit_data;
    end else begin
      m0_m1_fwd_valid <= 1'b0;
      m0_m1_fwd_data  <= '0;
    end
  end
`else
  assign m0_m1_fwd_valid = 1'b0;
  assign m0_m1_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_0_stage.sv
// Randomized bench for mem_0_stage against a queue-based reference model of the store buffer.
// Honours STORE_FWD_EN when defined for both the DUT and this bench.
module tb_mem_0_stage;

  localparam int SB_DEPTH = 4;
  localparam int ADDR_W   = 7;
`ifdef STORE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ex_oper = 0, ex_readmem = 0, ex_writemem = 0, ex_writereg = 0;
  logic [31:0] ex_alu_out = '0, ex_regb = '0;
  logic [4:0]  ex_regdest = '0;
  logic m0_ex_stall, m1_oper, m1_readmem, m1_writemem, m1_writereg, m1_fwd_valid, dmem_wre;
  logic [31:0] m1_data_addr, m1_regb, m1_fwd_data, dmem_wdata;
  logic [4:0]  m1_regdest;
  logic [ADDR_W-1:0] dmem_waddr;

  mem_0_stage #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .ex_m0_oper(ex_oper), .ex_m0_readmem(ex_readmem), .ex_m0_writemem(ex_writemem),
    .ex_m0_alu_out(ex_alu_out), .ex_m0_regb(ex_regb), .ex_m0_regdest(ex_regdest),
    .ex_m0_writereg(ex_writereg), .m0_ex_stall(m0_ex_stall),
    .m0_m1_oper(m1_oper), .m0_m1_readmem(m1_readmem), .m0_m1_writemem(m1_writemem),
    .m0_m1_writereg(m1_writereg), .m0_m1_data_addr(m1_data_addr), .m0_m1_regb(m1_regb),
    .m0_m1_regdest(m1_regdest), .m0_m1_fwd_valid(m1_fwd_valid), .m0_m1_fwd_data(m1_fwd_data),
    .dmem_wre(dmem_wre), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  logic b_oper, b_rd, b_wr, b_wreg, b_fwd_valid;
  logic [31:0] b_addr, b_regb, b_fwd_data;
  logic [4:0]  b_rdest;

  int n_vectors = 0;
  int n_errors  = 0;
  logic obs_stall, obs_wre, obs_fwd_valid;
  logic [31:0] obs_waddr, obs_wdata, obs_fwd_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    sb_q.delete();
    {b_oper, b_rd, b_wr, b_wreg, b_fwd_valid} = '0;
    b_addr = '0; b_regb = '0; b_rdest = '0; b_fwd_data = '0;
  endtask

  // One EX cycle: drive, check combinational and registered outputs at negedge, advance the model.
  task automatic applyStimulus(input logic op, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] rdest, input logic wreg);
    logic is_store, is_load, match, exp_stall, exp_wre, acc;
    logic [ADDR_W-1:0] wa;
    logic [31:0] youngest, exp_waddr, exp_wdata;
    ex_oper = op; ex_readmem = rd; ex_writemem = wr; ex_alu_out = addr;
    ex_regb = data; ex_regdest = rdest; ex_writereg = wreg;
    is_store = op && wr && !rd;
    is_load  = op && rd;
    wa = addr[ADDR_W+1:2];
    match = 1'b0; youngest = '0;
    foreach (sb_q[i]) if (sb_q[i].addr == wa) begin match = 1'b1; youngest = sb_q[i].data; end
    exp_stall = (is_store && sb_q.size() == SB_DEPTH) || (!FWD_EN && is_load && match);
    exp_wre   = !(b_oper && b_rd) && sb_q.size() > 0;
    exp_waddr = sb_q.size() > 0 ? 32'(sb_q[0].addr) : 32'd0;
    exp_wdata = sb_q.size() > 0 ? sb_q[0].data : 32'd0;
    @(negedge clock);
    obs_stall = m0_ex_stall; obs_wre = dmem_wre; obs_waddr = 32'(dmem_waddr);
    obs_wdata = dmem_wdata; obs_fwd_valid = m1_fwd_valid; obs_fwd_data = m1_fwd_data;
    checkOutput("stall", 32'(m0_ex_stall), 32'(exp_stall));
    checkOutput("dmem_wre", 32'(dmem_wre), 32'(exp_wre));
    checkOutput("dmem_waddr", 32'(dmem_waddr), exp_waddr);
    checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
    checkOutput("m1_oper", 32'(m1_oper), 32'(b_oper));
    checkOutput("m1_readmem", 32'(m1_readmem), 32'(b_rd));
    checkOutput("m1_writemem", 32'(m1_writemem), 32'(b_wr));
    checkOutput("m1_writereg", 32'(m1_writereg), 32'(b_wreg));
    checkOutput("m1_data_addr", m1_data_addr, b_addr);
    checkOutput("m1_regb", m1_regb, b_regb);
    checkOutput("m1_regdest", 32'(m1_regdest), 32'(b_rdest));
    checkOutput("m1_fwd_valid", 32'(m1_fwd_valid), 32'(b_fwd_valid));
    checkOutput("m1_fwd_data", m1_fwd_data, b_fwd_data);
    acc = op && !exp_stall;
    if (exp_wre) void'(sb_q.pop_front());
    if (acc && is_store) sb_q.push_back('{addr: wa, data: data});
    if (acc) begin
      b_oper = 1'b1; b_rd = rd; b_wr = wr && !is_store; b_wreg = wreg;
      b_addr = addr; b_regb = data; b_rdest = rdest;
      b_fwd_valid = FWD_EN && is_load && match;
      b_fwd_data  = (FWD_EN && is_load && match) ? youngest : 32'd0;
    end else begin
      {b_oper, b_rd, b_wr, b_wreg, b_fwd_valid} = '0;
      b_addr = '0; b_regb = '0; b_rdest = '0; b_fwd_data = '0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic doReset();
    ex_oper = 0; ex_readmem = 0; ex_writemem = 0; ex_writereg = 0;
    ex_alu_out = '0; ex_regb = '0; ex_regdest = '0;
    reset = 1'b1;
    #2;
    checkOutput("rst_oper", 32'(m1_oper), 32'd0);
    checkOutput("rst_readmem", 32'(m1_readmem), 32'd0);
    checkOutput("rst_writemem", 32'(m1_writemem), 32'd0);
    checkOutput("rst_data_addr", m1_data_addr, 32'd0);
    checkOutput("rst_regb", m1_regb, 32'd0);
    checkOutput("rst_fwd_valid", 32'(m1_fwd_valid), 32'd0);
    checkOutput("rst_stall", 32'(m0_ex_stall), 32'd0);
    checkOutput("rst_wre", 32'(dmem_wre), 32'd0);
    checkOutput("rst_waddr", 32'(dmem_waddr), 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    clearModel();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Re-present a load until it is accepted; returns how many cycles it stalled.
  task automatic issueLoad(input logic [31:0] addr, output int stalls);
    stalls = 0;
    for (int t = 0; t < 8; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'd0, 5'd3, 1'b1);
      if (!obs_stall) return;
      stalls++;
    end
    checkOutput("load_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int stalls;
    logic [31:0] a;
    int r;
    clearModel();
    @(posedge clock);
    #1;
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'hAABB, 5'd0, 1'b0);
    nop();
    checkOutput("dir_drain_wre", 32'(obs_wre), 32'd1);
    checkOutput("dir_drain_waddr", obs_waddr, 32'd4);
    checkOutput("dir_drain_wdata", obs_wdata, 32'hAABB);
    nop();
    checkOutput("dir_empty_wre", 32'(obs_wre), 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'(i + 100), 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h180 + 32'(i * 4), 32'd0, 5'd7, 1'b1);
    end
    nop(); nop();

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234, 5'd0, 1'b0);
    issueLoad(32'h20, stalls);
    checkOutput("dir_raw_stalls", 32'(stalls), FWD_EN ? 32'd0 : 32'd1);
    nop();
    checkOutput("dir_raw_fwd_valid", 32'(obs_fwd_valid), 32'(FWD_EN));
    checkOutput("dir_raw_fwd_data", obs_fwd_data, FWD_EN ? 32'h1234 : 32'd0);
    nop(); nop();

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'd1, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'd2, 5'd0, 1'b0);
    issueLoad(32'h8, stalls);
    nop();
    checkOutput("dir_young_fwd_data", obs_fwd_data, FWD_EN ? 32'd2 : 32'd0);
    nop(); nop();

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h30, 32'h55, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h34, 32'h66, 5'd0, 1'b0);
    doReset();
    nop();
    checkOutput("dir_rst_discard_wre", 32'(obs_wre), 32'd0);

    for (int i = 0; i < 600; i++) begin
      if (i % 151 == 150) doReset();
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (r < 2)
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom));
      else if (r < 6)
        applyStimulus(1'b1, 1'b0, 1'b1, a, $urandom, 5'($urandom), 1'($urandom));
      else if (r < 9)
        applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom), 1'b1);
      else
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
    $finish;
  end

endmodule
